pll_reconfig_seq: RTL and testbench

//  Sequences the core's fractional PLL: power-up reset/lock, and runtime retune to one of
//  NUM_PROFILES stored frequency/phase profiles through the altera_pll_reconfig Avalon-MM port.

---
 rtl/pll_reconfig_pkg.sv | 44 ++++
 rtl/pll_reconfig_seq_if.sv | 34 +++
 rtl/pll_reconfig_rom.sv | 53 +++++
 rtl/pll_reconfig_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_pll_reconfig_seq.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pll_reconfig_pkg.sv
// Shared definitions for the PLL reconfiguration sequencer: management
// register map, sequencer states, profile word layout and a counter helper.
package pll_reconfig_pkg;

  // altera_pll_reconfig register addresses
  localparam logic [5:0] ADDR_MODE   = 6'h00;
  localparam logic [5:0] ADDR_STATUS = 6'h01;
  localparam logic [5:0] ADDR_START  = 6'h02;
  localparam logic [5:0] ADDR_N      = 6'h03;
  localparam logic [5:0] ADDR_M      = 6'h04;
  localparam logic [5:0] ADDR_C      = 6'h05;
  localparam logic [5:0] ADDR_MFRAC  = 6'h07;
  localparam logic [5:0] ADDR_BW     = 6'h08;

  // Capacity of the profile table; the sequencer may use fewer of either
  localparam int MAX_PROFILES = 4;
  localparam int MAX_WORDS    = 6;
  localparam int PROF_IDX_W   = 2;
  localparam int WORD_IDX_W   = 3;

  typedef enum logic [3:0] {
    ST_PWR_RST,
    ST_PWR_LOCK,
    ST_IDLE,
    ST_MODE,
    ST_WRITE,
    ST_START,
    ST_POLL,
    ST_LOCK,
    ST_OK,
    ST_FAIL
  } seq_state_e;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } prof_word_t;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pll_reconfig_seq_if.sv
// Request/status and Avalon-MM management signals of the PLL sequencer.
// The master side is the sequencer; the slave side is the requesting
// logic, the PLL and its reconfig block.
interface pll_reconfig_seq_if #(
  parameter int PW = 1
);
  logic          req;
  logic [PW-1:0] req_profile;
  logic          busy;
  logic          done;
  logic          err;
  logic          pll_ready;
  logic [PW-1:0] cur_profile;
  logic          pll_rst;
  logic          pll_locked;
  logic [5:0]    mgmt_address;
  logic          mgmt_read;
  logic          mgmt_write;
  logic [31:0]   mgmt_writedata;
  logic [31:0]   mgmt_readdata;
  logic          mgmt_waitrequest;

  modport master (
    input  req, req_profile, pll_locked, mgmt_readdata, mgmt_waitrequest,
    output busy, done, err, pll_ready, cur_profile, pll_rst,
           mgmt_address, mgmt_read, mgmt_write, mgmt_writedata
  );

  modport slave (
    output req, req_profile, pll_locked, mgmt_readdata, mgmt_waitrequest,
    input  busy, done, err, pll_ready, cur_profile, pll_rst,
           mgmt_address, mgmt_read, mgmt_write, mgmt_writedata
  );
endinterface

// File: rtl/pll_reconfig_rom.sv
// Profile table: for each profile, the ordered (address, data) register
// writes that retune the PLL. Purely combinational lookup.
module pll_reconfig_rom
  import pll_reconfig_pkg::*;
(
  input  logic [PROF_IDX_W-1:0] profile_i,
  input  logic [WORD_IDX_W-1:0] word_i,
  output prof_word_t            word_o
);

  // Row order per profile: N, M, C0, C1, M fraction, bandwidth
  localparam prof_word_t TABLE [MAX_PROFILES*MAX_WORDS] = '{
    '{addr: ADDR_N,     data: 32'h0001_0000},
    '{addr: ADDR_M,     data: 32'h0000_0606},
    '{addr: ADDR_C,     data: 32'h0000_0808},
    '{addr: ADDR_C,     data: 32'h0004_0808},
    '{addr: ADDR_MFRAC, data: 32'h0000_0000},
    '{addr: ADDR_BW,    data: 32'h0000_0006},

    '{addr: ADDR_N,     data: 32'h0000_0101},
    '{addr: ADDR_M,     data: 32'h0000_0807},
    '{addr: ADDR_C,     data: 32'h0000_0A0A},
    '{addr: ADDR_C,     data: 32'h0004_0A09},
    '{addr: ADDR_MFRAC, data: 32'h3D70_A3D7},
    '{addr: ADDR_BW,    data: 32'h0000_0007},

    '{addr: ADDR_N,     data: 32'h0000_0202},
    '{addr: ADDR_M,     data: 32'h0000_0C0C},
    '{addr: ADDR_C,     data: 32'h0000_0505},
    '{addr: ADDR_C,     data: 32'h0004_0605},
    '{addr: ADDR_MFRAC, data: 32'h8000_0000},
    '{addr: ADDR_BW,    data: 32'h0000_0006},

    '{addr: ADDR_N,     data: 32'h0001_0000},
    '{addr: ADDR_M,     data: 32'h0000_0404},
    '{addr: ADDR_C,     data: 32'h0000_0404},
    '{addr: ADDR_C,     data: 32'h0004_0404},
    '{addr: ADDR_MFRAC, data: 32'h0000_0000},
    '{addr: ADDR_BW,    data: 32'h0000_0008}
  };

  logic [4:0] idx;

  // Flatten {profile, word} into a table row; unused word slots read as a harmless zero write
  always_comb begin
    idx    = 5'(profile_i) * 5'(MAX_WORDS) + 5'(word_i);
    word_o = '{addr: ADDR_MODE, data: 32'h0};
    if (word_i < WORD_IDX_W'(MAX_WORDS)) begin
      word_o = TABLE[idx];
    end
  end

endmodule

// File: rtl/pll_reconfig_seq.sv
// PLL sequencer: holds the PLL in reset at power-up and waits for lock, then
// retunes on request by streaming a stored profile into altera_pll_reconfig
// and waiting for the reconfig block and the PLL to settle.
module pll_reconfig_seq
  import pll_reconfig_pkg::*;
#(
  parameter int NUM_PROFILES = 2,
  parameter int WORDS        = 6,
  parameter int RST_CYCLES   = 64,
  parameter int LOCK_TIMEOUT = 1048576,
  parameter int POLL_LIMIT   = 4096
) (
  input logic                clk_74a,
  input logic                reset_n,
  pll_reconfig_seq_if.master io
);

  localparam int PW = (NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1;

  seq_state_e                state_q;
  logic [31:0]               cnt_q;
  logic [WORD_IDX_W-1:0]     word_q;
  logic [PW-1:0]             prof_q;
  logic [PW-1:0]             cur_q;
  logic                      lock_meta_q;
  logic                      lock_sync_q;
  logic                      pll_rst_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      err_q;
  logic [5:0]                addr_q;
  logic [31:0]               wdata_q;
  logic                      read_q;
  logic                      write_q;

  prof_word_t                rom_word;
  logic                      bus_act;
  logic                      bus_ack;
  logic                      bad_index;
  logic                      unused_rdata;

  assign bus_act      = read_q | write_q;
  assign bus_ack      = bus_act & ~io.mgmt_waitrequest;
  assign bad_index    = ({{(32-PW){1'b0}}, io.req_profile} >= 32'(NUM_PROFILES));
  assign unused_rdata = ^io.mgmt_readdata[31:1];

  pll_reconfig_rom u_rom (
    .profile_i (PROF_IDX_W'(prof_q)),
    .word_i    (word_q),
    .word_o    (rom_word)
  );

  // Bring the asynchronous PLL lock indication into the clk_74a domain
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      lock_meta_q <= io.pll_locked;
      lock_sync_q <= lock_meta_q;
    end
  end

  // Sequencer: each bus access is raised, held through waitrequest, dropped for one cycle after acceptance
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_PWR_RST;
      cnt_q     <= '0;
      word_q    <= '0;
      prof_q    <= '0;
      cur_q     <= '0;
      pll_rst_q <= 1'b1;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_PWR_RST: begin
          pll_rst_q <= 1'b1;
          busy_q    <= 1'b1;
          if (cnt_q >= 32'(RST_CYCLES - 1)) begin
            pll_rst_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= ST_PWR_LOCK;
          end else begin
            cnt_q <= sat_inc(cnt_q);
          end
        end

        ST_PWR_LOCK: begin
          if (lock_sync_q) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else if (cnt_q >= 32'(LOCK_TIMEOUT - 1)) begin
            pll_rst_q <= 1'b1;
            cnt_q     <= '0;
            state_q   <= ST_PWR_RST;
          end else begin
            cnt_q <= sat_inc(cnt_q);
          end
        end

        ST_IDLE: begin
          busy_q <= 1'b0;
          if (io.req) begin
            if (bad_index) begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
              prof_q  <= io.req_profile;
              busy_q  <= 1'b1;
              state_q <= ST_MODE;
            end
          end
        end

        ST_MODE: begin
          if (!bus_act) begin
            write_q <= 1'b1;
            addr_q  <= ADDR_MODE;
            wdata_q <= 32'd1;
          end else if (bus_ack) begin
            write_q <= 1'b0;
            word_q  <= '0;
            state_q <= ST_WRITE;
          end
        end

        ST_WRITE: begin
          if (!bus_act) begin
            write_q <= 1'b1;
            addr_q  <= rom_word.addr;
            wdata_q <= rom_word.data;
          end else if (bus_ack) begin
            write_q <= 1'b0;
            if (word_q == WORD_IDX_W'(WORDS - 1)) begin
              state_q <= ST_START;
            end else begin
              word_q <= word_q + 1'b1;
            end
          end
        end

        ST_START: begin
          if (!bus_act) begin
            write_q <= 1'b1;
            addr_q  <= ADDR_START;
            wdata_q <= 32'd0;
          end else if (bus_ack) begin
            write_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= ST_POLL;
          end
        end

        ST_POLL: begin
          if (!bus_act) begin
            read_q <= 1'b1;
            addr_q <= ADDR_STATUS;
          end else if (bus_ack) begin
            read_q <= 1'b0;
            if (io.mgmt_readdata[0]) begin
              cnt_q   <= '0;
              state_q <= ST_LOCK;
            end else if (cnt_q >= 32'(POLL_LIMIT - 1)) begin
              state_q <= ST_FAIL;
            end else begin
              cnt_q <= sat_inc(cnt_q);
            end
          end
        end

        ST_LOCK: begin
          if (lock_sync_q) begin
            state_q <= ST_OK;
          end else if (cnt_q >= 32'(LOCK_TIMEOUT - 1)) begin
            state_q <= ST_FAIL;
          end else begin
            cnt_q <= sat_inc(cnt_q);
          end
        end

        ST_OK: begin
          cur_q   <= prof_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        ST_FAIL: begin
          done_q  <= 1'b1;
          err_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_PWR_RST;
        end
      endcase
    end
  end

  assign io.busy           = busy_q;
  assign io.done           = done_q;
  assign io.err            = err_q;
  assign io.pll_ready      = (state_q == ST_IDLE) && lock_sync_q && !busy_q;
  assign io.cur_profile    = cur_q;
  assign io.pll_rst        = pll_rst_q;
  assign io.mgmt_address   = addr_q;
  assign io.mgmt_read      = read_q;
  assign io.mgmt_write     = write_q;
  assign io.mgmt_writedata = wdata_q;

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Bench for pll_reconfig_seq: an Avalon slave model answers the management
// port, expected bus accesses and results are queued when a request is made
// and compared as the sequencer produces them.
module tb_pll_reconfig_seq;

  localparam int NPROF   = 3;
  localparam int PW      = 2;
  localparam int WORDS   = 6;
  localparam int RSTC    = 64;
  localparam int LOCKTO  = 2000;
  localparam int POLLLIM = 4096;

  // Independent copy of the profile table: {addr, data}
  localparam logic [37:0] ROM_MODEL [0:23] = '{
    {6'h03, 32'h0001_0000}, {6'h04, 32'h0000_0606}, {6'h05, 32'h0000_0808},
    {6'h05, 32'h0004_0808}, {6'h07, 32'h0000_0000}, {6'h08, 32'h0000_0006},
    {6'h03, 32'h0000_0101}, {6'h04, 32'h0000_0807}, {6'h05, 32'h0000_0A0A},
    {6'h05, 32'h0004_0A09}, {6'h07, 32'h3D70_A3D7}, {6'h08, 32'h0000_0007},
    {6'h03, 32'h0000_0202}, {6'h04, 32'h0000_0C0C}, {6'h05, 32'h0000_0505},
    {6'h05, 32'h0004_0605}, {6'h07, 32'h8000_0000}, {6'h08, 32'h0000_0006},
    {6'h03, 32'h0001_0000}, {6'h04, 32'h0000_0404}, {6'h05, 32'h0000_0404},
    {6'h05, 32'h0004_0404}, {6'h07, 32'h0000_0000}, {6'h08, 32'h0000_0008}
  };

  logic clk    = 1'b0;
  logic resetN = 1'b0;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [39:0]   expBus[$];
  logic [PW:0]   expRes[$];
  logic [PW-1:0] curModel = '0;

  int waitCycles  = 0;
  int statusAfter = 0;
  int waitCnt     = 0;
  int readsSeen   = 0;
  int writesSeen  = 0;
  int doneCnt     = 0;
  int cycleCnt    = 0;
  int acceptCycle = 0;
  int doneCycle   = 0;
  bit rwBoth      = 1'b0;

  pll_reconfig_seq_if #(.PW(PW)) bus ();

  pll_reconfig_seq #(
    .NUM_PROFILES (NPROF),
    .WORDS        (WORDS),
    .RST_CYCLES   (RSTC),
    .LOCK_TIMEOUT (LOCKTO),
    .POLL_LIMIT   (POLLLIM)
  ) dut (
    .clk_74a (clk),
    .reset_n (resetN),
    .io      (bus)
  );

  always #5 clk = ~clk;

  // Cycle counter for latency measurements
  always @(posedge clk) cycleCnt++;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Avalon slave: stalls each access waitCycles cycles, scoreboards the accepted access
  always @(negedge clk) begin
    logic [39:0] actual;
    if (bus.mgmt_read && bus.mgmt_write) rwBoth = 1'b1;
    if (!(bus.mgmt_read || bus.mgmt_write)) begin
      waitCnt               = 0;
      bus.mgmt_waitrequest  = 1'b1;
      bus.mgmt_readdata     = 32'h0;
    end else if (waitCnt < waitCycles) begin
      waitCnt++;
      bus.mgmt_waitrequest = 1'b1;
    end else begin
      waitCnt              = 0;
      bus.mgmt_waitrequest = 1'b0;
      if (bus.mgmt_read) begin
        readsSeen++;
        acceptCycle       = cycleCnt;
        bus.mgmt_readdata = 32'hA5A5_0000 |
                            (((statusAfter != 0) && (readsSeen >= statusAfter)) ? 32'd1 : 32'd0);
      end else begin
        writesSeen++;
      end
      actual = {bus.mgmt_write, bus.mgmt_read, bus.mgmt_address,
                bus.mgmt_write ? bus.mgmt_writedata : 32'h0};
      if (expBus.size() == 0) checkOutput("bus_extra", 64'(actual), 64'h0);
      else                    checkOutput("bus_op", 64'(actual), 64'(expBus.pop_front()));
    end
  end

  // Result monitor: every done pulse is matched against the queued outcome
  always @(negedge clk) begin
    if (resetN && bus.done) begin
      doneCnt++;
      doneCycle = cycleCnt;
      if (expRes.size() == 0) checkOutput("done_extra", 64'd1, 64'd0);
      else checkOutput("result_err_cur", 64'({bus.err, bus.cur_profile}), 64'(expRes.pop_front()));
    end
  end

  // Queue the expected accesses and outcome, then strobe req for one cycle
  task automatic applyStimulus(input logic [PW-1:0] prof, input int nReads, input bit expErr);
    if (int'(prof) < NPROF) begin
      expBus.push_back({1'b1, 1'b0, 6'h00, 32'd1});
      for (int w = 0; w < WORDS; w++) expBus.push_back({1'b1, 1'b0, ROM_MODEL[int'(prof)*6 + w]});
      expBus.push_back({1'b1, 1'b0, 6'h02, 32'd0});
      for (int r = 0; r < nReads; r++) expBus.push_back({1'b0, 1'b1, 6'h01, 32'h0});
    end
    expRes.push_back({expErr, expErr ? curModel : prof});
    if (!expErr) curModel = prof;
    bus.req_profile = prof;
    bus.req         = 1'b1;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
  endtask

  task automatic waitForDone(input string tag, input int maxCycles);
    int startCnt = doneCnt;
    int i = 0;
    while (doneCnt == startCnt && i < maxCycles) begin
      @(posedge clk);
      i++;
    end
    #1;
    checkOutput(tag, 64'(doneCnt != startCnt), 64'd1);
  endtask

  // Called just after reset_n is released on a posedge+1
  task automatic checkPllRstRelease(input string tag);
    repeat (RSTC - 1) @(posedge clk);
    #1;
    checkOutput({tag, "_pllrst_hold"}, 64'(bus.pll_rst), 64'd1);
    @(posedge clk);
    #1;
    checkOutput({tag, "_pllrst_fall"}, 64'(bus.pll_rst), 64'd0);
  endtask

  task automatic waitReady(input string tag, input int maxCycles);
    for (int i = 0; i < maxCycles && !bus.pll_ready; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput({tag, "_ready"}, 64'(bus.pll_ready), 64'd1);
    checkOutput({tag, "_busy"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int startDone;
    int wsStart;
    int lat;

    bus.req         = 1'b0;
    bus.req_profile = '0;
    bus.pll_locked  = 1'b0;

    // 1: reset values, power-up release and lock
    resetN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_pll_rst", 64'(bus.pll_rst), 64'd1);
    checkOutput("rst_busy", 64'(bus.busy), 64'd1);
    checkOutput("rst_done", 64'(bus.done), 64'd0);
    checkOutput("rst_err", 64'(bus.err), 64'd0);
    checkOutput("rst_ready", 64'(bus.pll_ready), 64'd0);
    checkOutput("rst_cur", 64'(bus.cur_profile), 64'd0);
    checkOutput("rst_read", 64'(bus.mgmt_read), 64'd0);
    checkOutput("rst_write", 64'(bus.mgmt_write), 64'd0);
    checkOutput("rst_addr", 64'(bus.mgmt_address), 64'd0);
    checkOutput("rst_wdata", 64'(bus.mgmt_writedata), 64'd0);
    resetN = 1'b1;
    checkPllRstRelease("t1");
    repeat (35) @(posedge clk);
    #1;
    bus.req_profile = 2'd1;
    bus.req         = 1'b1;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    checkOutput("t1_req_ignored_busy", 64'(bus.busy), 64'd1);
    checkOutput("t1_not_ready", 64'(bus.pll_ready), 64'd0);
    bus.pll_locked = 1'b1;
    waitReady("t1", 3);
    checkOutput("t1_no_done", 64'(doneCnt), 64'd0);
    checkOutput("t1_no_bus", 64'(writesSeen + readsSeen), 64'd0);

    // 2: retune to profile 1 with stalled accesses, status set on third read
    waitCycles  = 2;
    statusAfter = 3;
    readsSeen   = 0;
    applyStimulus(2'd1, 3, 1'b0);
    waitForDone("t2_done_seen", 500);
    checkOutput("t2_busy", 64'(bus.busy), 64'd0);
    checkOutput("t2_cur", 64'(bus.cur_profile), 64'd1);
    checkOutput("t2_reads", 64'(readsSeen), 64'd3);
    checkOutput("t2_queue_empty", 64'(expBus.size()), 64'd0);
    checkOutput("t2_ready", 64'(bus.pll_ready), 64'd1);

    // 3: out-of-range profile index
    repeat (3) @(posedge clk);
    #1;
    startDone = doneCnt;
    applyStimulus(2'd3, 0, 1'b1);
    checkOutput("t3_done", 64'(bus.done), 64'd1);
    checkOutput("t3_err", 64'(bus.err), 64'd1);
    checkOutput("t3_busy", 64'(bus.busy), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("t3_one_done", 64'(doneCnt - startDone), 64'd1);
    checkOutput("t3_no_bus", 64'(bus.mgmt_read | bus.mgmt_write), 64'd0);

    // 4: status never set, poll limit
    waitCycles  = 0;
    statusAfter = 0;
    readsSeen   = 0;
    applyStimulus(2'd2, POLLLIM, 1'b1);
    waitForDone("t4_done_seen", 3 * POLLLIM + 200);
    checkOutput("t4_reads", 64'(readsSeen), 64'(POLLLIM));
    checkOutput("t4_cur", 64'(bus.cur_profile), 64'd1);
    checkOutput("t4_queue_empty", 64'(expBus.size()), 64'd0);

    // 5: lock loss in idle, then lock timeout with a request dropped while busy
    bus.pll_locked = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t5_ready_loss", 64'(bus.pll_ready), 64'd0);
    waitCycles  = 1;
    statusAfter = 1;
    readsSeen   = 0;
    startDone   = doneCnt;
    applyStimulus(2'd0, 1, 1'b1);
    repeat (40) @(posedge clk);
    #1;
    checkOutput("t5_busy_mid", 64'(bus.busy), 64'd1);
    bus.req_profile = 2'd1;
    bus.req         = 1'b1;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    waitForDone("t5_done_seen", LOCKTO + 300);
    lat = doneCycle - acceptCycle;
    checkOutput("t5_lock_timeout_window", 64'((lat >= LOCKTO) && (lat <= LOCKTO + 4)), 64'd1);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("t5_one_done", 64'(doneCnt - startDone), 64'd1);
    checkOutput("t5_cur", 64'(bus.cur_profile), 64'd1);
    bus.pll_locked = 1'b1;
    waitReady("t5_relock", 4);

    // 6: reset asserted while a profile write is stalled
    waitCycles  = 0;
    statusAfter = 1;
    wsStart     = writesSeen;
    applyStimulus(2'd1, 1, 1'b0);
    for (int i = 0; i < 400 && writesSeen < wsStart + 3; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("t6_reach_write", 64'(writesSeen >= wsStart + 3), 64'd1);
    waitCycles = 1000;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t6_write_stalled", 64'(bus.mgmt_write), 64'd1);
    #2;
    resetN = 1'b0;
    #1;
    checkOutput("t6_write_abort", 64'(bus.mgmt_write), 64'd0);
    checkOutput("t6_pll_rst", 64'(bus.pll_rst), 64'd1);
    checkOutput("t6_busy", 64'(bus.busy), 64'd1);
    expBus.delete();
    expRes.delete();
    curModel   = '0;
    waitCycles = 0;
    @(posedge clk);
    #1;
    resetN = 1'b1;
    checkPllRstRelease("t6");
    waitReady("t6", 4);
    checkOutput("t6_cur", 64'(bus.cur_profile), 64'd0);

    checkOutput("rw_exclusive", 64'(rwBoth), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
